phase_cycle_sequencer: RTL and testbench
========================================

PHASE_CYCLE_SEQUENCER -- requirements
Module: phase_cycle_sequencer

Interface
REQ-001 Parameter SCAN_W, default 16: width of the scan-count configuration and status.
REQ-002 clk  in  1  single system clock; all logic rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins a phase-cycled acquisition run.
REQ-005 abort  in  1  one-cycle pulse; terminates a run immediately.
REQ-006 scan_done  in  1  one-cycle pulse; the current scan (TX+RX) is complete.
REQ-007 n_phases  in  2  number of phase-list slots in use (1..3); 0 is treated as 1.
REQ-008 n_scans  in  SCAN_W  total scans in the run; 0 means an empty run.
REQ-009 phase_selector  out  2  index into the 3-slot phase list consumed by the downstream phase selector.
REQ-010 busy  out  1  high while a run is active.
REQ-011 scan_count  out  SCAN_W  scans completed in the current or last run.
REQ-012 done  out  1  one-cycle pulse at run completion, not asserted on abort.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FINISH; IDLE is the reset state.
REQ-014 In IDLE, start SHALL latch n_phases (0 mapped to 1) and n_scans into internal registers, clear scan_count and phase_selector, and move to RUN next cycle.
REQ-015 Inputs n_phases and n_scans SHALL be ignored outside the start cycle; mid-run changes have no effect.
REQ-016 busy SHALL be high in RUN and FINISH and low in IDLE; latency from start to busy is exactly 1 cycle.
REQ-017 In RUN, each scan_done SHALL increment scan_count by 1 and advance phase_selector by 1, wrapping to 0 after latched_n_phases-1.
REQ-018 phase_selector SHALL never exceed 2 and SHALL change only on the cycle after a scan_done, holding steady between scans.
REQ-019 When a scan_done makes scan_count equal latched n_scans, the FSM SHALL enter FINISH; phase_selector is not advanced past the last scan, holding the last value used.
REQ-020 FINISH SHALL last exactly one cycle, assert done for that cycle, then return to IDLE.
REQ-021 If latched n_scans is 0, the FSM SHALL go RUN -> FINISH on the first RUN cycle without waiting for scan_done.
REQ-022 abort in RUN or FINISH SHALL return to IDLE next cycle with done low; scan_count holds its value; phase_selector resets to 0.
REQ-023 abort and scan_done in the same cycle: abort wins, scan_count is not incremented.
REQ-024 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-025 scan_done in IDLE or FINISH SHALL be ignored.
REQ-026 scan_count SHALL saturate at 2^SCAN_W-1 and never wrap.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, phase_selector 0, busy 0, done 0, scan_count 0, latched config 0.
REQ-028 Reset asserted mid-run SHALL abandon the run with no done pulse; release returns to IDLE awaiting start.

Structure
REQ-029 FSM state encoding and the phase-slot count constant (3) SHALL live in the shared NMR package, alongside the phase-list width (6 bits).
REQ-030 A sub-module phase_index_counter (modulo-N 2-bit counter with enable, clear, modulus input) SHALL implement REQ-017/018; the remainder is one FSM module.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 n_phases=3, n_scans=6, start, six scan_done pulses 10 cycles apart -> phase_selector 0,1,2,0,1,2 per scan; scan_count 6; done one cycle; busy low after.
REQ-033 n_phases=2, n_scans=5 -> selector sequence 0,1,0,1,0; n_phases=0, n_scans=3 -> selector stays 0 throughout.
REQ-034 n_scans=0, start -> busy 1 cycle in RUN, FINISH with done 1 cycle, scan_count 0, no scan_done needed.
REQ-035 n_phases=3, n_scans=10, abort coincident with 4th scan_done -> scan_count 3, done never asserted, phase_selector 0, busy low.
REQ-036 Start during RUN and scan_done in IDLE injected; rst_n pulsed low mid-run after 2 scans -> injected events ignored; reset clears all outputs immediately, no done.

Source files
------------

// File: rtl/phase_cycle_sequencer_pkg.sv
// Shared definitions for the phase-cycled acquisition sequencer.
//   state_t          : FSM state encoding (IDLE / RUN / FINISH)
//   PHASE_SLOTS      : number of entries in the downstream phase list
//   PHASE_W          : width of one phase-list entry
//   map_phases()     : maps a requested slot count of 0 to 1
package phase_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int PHASE_SLOTS = 3;
    localparam int PHASE_W     = 6;

    function automatic logic [1:0] map_phases(input logic [1:0] n);
        return (n == 2'd0) ? 2'd1 : n;
    endfunction

endpackage

// File: rtl/phase_cycle_sequencer_phase_index_counter.sv
// Modulo-N phase-slot index counter.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous return to slot 0 (wins over enable)
//   enable     : advance one slot, wrapping after modulus-1
//   modulus    : number of slots in use (1..3, 0 behaves as 1)
//   index      : registered slot index, never above PHASE_SLOTS-1
module phase_index_counter
    import phase_cycle_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] modulus,
    output logic [1:0] index
);

    logic [1:0] last_idx;

    // Comparing with >= rather than == keeps the index in range even if
    // the modulus shrinks underneath a non-zero index.
    always_comb begin
        last_idx = (modulus == 2'd0) ? 2'd0 : modulus - 2'd1;
        if (last_idx > 2'(PHASE_SLOTS - 1)) begin
            last_idx = 2'(PHASE_SLOTS - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= 2'd0;
        end else if (clear) begin
            index <= 2'd0;
        end else if (enable) begin
            index <= (index >= last_idx) ? 2'd0 : index + 2'd1;
        end
    end

endmodule

// File: rtl/phase_cycle_sequencer.sv
// Phase-cycled acquisition run sequencer.
//   clk, rst_n      : clock, async active-low reset
//   start           : pulse, begins a run (latches n_phases / n_scans)
//   abort           : pulse, ends a run at once without done
//   scan_done       : pulse, one scan of the run has completed
//   n_phases        : phase slots in use (0 treated as 1)
//   n_scans         : scans in the run (0 = empty run)
//   phase_selector  : registered phase-list slot for the current scan
//   busy            : registered, high in RUN and FINISH
//   scan_count      : registered, scans completed (saturating)
//   done            : registered one-cycle pulse in FINISH
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start; outputs hold last run result
// ST_RUN    | counting scan_done pulses, cycling phase slots
// ST_FINISH | one cycle with done high, then back to IDLE
module phase_cycle_sequencer
    import phase_cycle_sequencer_pkg::*;
#(
    parameter int SCAN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              scan_done,
    input  logic [1:0]        n_phases,
    input  logic [SCAN_W-1:0] n_scans,
    output logic [1:0]        phase_selector,
    output logic              busy,
    output logic [SCAN_W-1:0] scan_count,
    output logic              done
);

    localparam logic [SCAN_W-1:0] COUNT_ONE = {{(SCAN_W-1){1'b0}}, 1'b1};
    localparam logic [SCAN_W-1:0] COUNT_MAX = {SCAN_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lat_phases;
    logic [SCAN_W-1:0] lat_scans;
    logic [SCAN_W-1:0] count_inc;
    logic              start_ok;
    logic              scan_ok;
    logic              last_scan;
    logic              busy_nxt;
    logic              done_nxt;
    logic              phase_clear;
    logic              phase_adv;

    assign start_ok  = (state == ST_IDLE) && start && !abort;
    // An empty run never consumes scan_done; it goes straight to FINISH.
    assign scan_ok   = (state == ST_RUN) && scan_done && !abort && (lat_scans != '0);
    assign count_inc = (scan_count == COUNT_MAX) ? scan_count : scan_count + COUNT_ONE;
    assign last_scan = scan_ok && (count_inc == lat_scans);

    // Abort in IDLE leaves the held result of the previous run untouched.
    assign phase_clear = start_ok || (abort && (state != ST_IDLE));
    // The final scan does not advance the slot so the last-used one stays visible.
    assign phase_adv   = scan_ok && !last_scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if ((lat_scans == '0) || last_scan) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            lat_phases <= 2'd0;
            lat_scans  <= '0;
            scan_count <= '0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (start_ok) begin
                lat_phases <= map_phases(n_phases);
                lat_scans  <= n_scans;
                scan_count <= '0;
            end else if (scan_ok) begin
                scan_count <= count_inc;
            end
        end
    end

    phase_index_counter u_phase_index_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (phase_clear),
        .enable  (phase_adv),
        .modulus (lat_phases),
        .index   (phase_selector)
    );

endmodule

// File: tb/tb_phase_cycle_sequencer.sv
module tb_phase_cycle_sequencer;

    localparam int SCAN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              scan_done = 1'b0;
    logic [1:0]        n_phases = 2'd0;
    logic [SCAN_W-1:0] n_scans = '0;
    logic [1:0]        phase_selector;
    logic              busy;
    logic [SCAN_W-1:0] scan_count;
    logic              done;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    phase_cycle_sequencer #(.SCAN_W(SCAN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .scan_done      (scan_done),
        .n_phases       (n_phases),
        .n_scans        (n_scans),
        .phase_selector (phase_selector),
        .busy           (busy),
        .scan_count     (scan_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: run-level behaviour in plain arithmetic.
    // mode 0 = idle, 1 = run, 2 = finish
    int     m_mode = 0;
    int     m_np = 0;
    longint m_ns = 0;
    longint m_count = 0;
    int     m_phase = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_np = 0; m_ns = 0; m_count = 0; m_phase = 0;
        end else begin
            case (m_mode)
                0: if (start && !abort) begin
                    m_mode  = 1;
                    m_np    = (n_phases == 0) ? 1 : int'(n_phases);
                    m_ns    = longint'(n_scans);
                    m_count = 0;
                    m_phase = 0;
                end
                1: if (abort) begin
                    m_mode = 0; m_phase = 0;
                end else if (m_ns == 0) begin
                    m_mode = 2;
                end else if (scan_done) begin
                    if (m_count < (64'd1 << SCAN_W) - 1) m_count++;
                    if (m_count == m_ns) m_mode = 2;
                    else m_phase = int'(m_count % m_np);
                end
                default: begin
                    m_mode = 0;
                    if (abort) m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_busy", busy, (m_mode != 0));
            chk("model_done", done, (m_mode == 2));
            chk("model_count", scan_count, m_count);
            chk("model_phase", phase_selector, m_phase);
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_scan();
        scan_done = 1'b1; cyc(); scan_done = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  np;
        int          ns;
        int          gap;
        logic [15:0] exp_sel;   // 2 bits per scan, scan 0 in [1:0]
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int id);
        string tag;
        tag = $sformatf("vec%0d", id);
        n_phases = v.np; n_scans = SCAN_W'(v.ns);
        start = 1'b1; cyc(); start = 1'b0;
        n_phases = 2'd3; n_scans = 16'd99;   // must not affect the run
        chk({tag, "_busy_latency"}, busy, 1);
        chk({tag, "_count_clear"}, scan_count, 0);
        chk({tag, "_sel_clear"}, phase_selector, 0);
        if (v.ns == 0) begin
            chk({tag, "_run_done_low"}, done, 0);
            cyc();
            chk({tag, "_empty_done"}, done, 1);
            chk({tag, "_empty_busy"}, busy, 1);
            cyc();
            chk({tag, "_empty_done_end"}, done, 0);
            chk({tag, "_empty_idle"}, busy, 0);
            chk({tag, "_empty_count"}, scan_count, 0);
        end else begin
            for (int k = 0; k < v.ns; k++) begin
                for (int g = 0; g < v.gap; g++) begin
                    chk({tag, "_sel"}, phase_selector, v.exp_sel[2*k +: 2]);
                    chk({tag, "_no_done"}, done, 0);
                    cyc();
                end
                pulse_scan();
            end
            chk({tag, "_done"}, done, 1);
            chk({tag, "_count"}, scan_count, v.ns);
            chk({tag, "_sel_hold"}, phase_selector, v.exp_sel[2*(v.ns-1) +: 2]);
            cyc();
            chk({tag, "_done_end"}, done, 0);
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_sel_idle"}, phase_selector, v.exp_sel[2*(v.ns-1) +: 2]);
        end
        cyc(2);
    endtask

    initial begin
        vecs[0] = '{np: 2'd3, ns: 6, gap: 10, exp_sel: 16'b0000_1001_0010_0100 | 16'h0};
        vecs[0].exp_sel = {4'b0000, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
        vecs[1] = '{np: 2'd2, ns: 5, gap: 4, exp_sel: {6'b0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0}};
        vecs[2] = '{np: 2'd0, ns: 3, gap: 3, exp_sel: 16'd0};
        vecs[3] = '{np: 2'd1, ns: 4, gap: 2, exp_sel: 16'd0};
        vecs[4] = '{np: 2'd3, ns: 0, gap: 1, exp_sel: 16'd0};

        cyc(2);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_count", scan_count, 0);
        chk("reset_sel", phase_selector, 0);
        rst_n = 1'b1;
        cyc();
        check_en = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // abort coincident with the 4th scan_done
        n_phases = 2'd3; n_scans = 16'd10;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin cyc(3); pulse_scan(); end
        chk("abort_pre_sel", phase_selector, 0);
        cyc(2);
        scan_done = 1'b1; abort = 1'b1; cyc(); scan_done = 1'b0; abort = 1'b0;
        chk("abort_count", scan_count, 3);
        chk("abort_sel", phase_selector, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        cyc(3);
        chk("abort_done_later", done, 0);

        // start + abort together in IDLE: stay idle
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // scan_done in IDLE ignored
        pulse_scan();
        chk("idle_scan_count", scan_count, 3);

        // start during RUN ignored, config change ignored, then reset mid-run
        n_phases = 2'd3; n_scans = 16'd10;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(2); pulse_scan();
        n_phases = 2'd1; n_scans = 16'd2;
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_ignored_count", scan_count, 1);
        cyc(2); pulse_scan();
        chk("midrun_cfg_sel", phase_selector, 2);
        chk("midrun_cfg_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_count", scan_count, 0);
        chk("rst_sel", phase_selector, 0);
        chk("rst_done", done, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_release_idle", busy, 0);

        // random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 14) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            scan_done = ($urandom_range(0, 2) == 0);
            n_phases  = 2'($urandom_range(0, 3));
            n_scans   = SCAN_W'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cyc();
        end
        start = 1'b0; abort = 1'b0; scan_done = 1'b0; rst_n = 1'b1;
        cyc(3);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
